alu_group_sequencer: RTL and testbench
======================================

Name: alu_group_sequencer

Overview:
Parametrised next-generation ALU-group (GPF=2'b11) decoder and sequencer. It latches the ALU instruction at DECODE and drives register-file read/write enables and port addresses, ALU operand source selects and flag write-enable across the DECODE/EXECUTE/COMMIT phases. Unlike the single-cycle decoder, it supports multi-cycle ALU ops, holding a STALL to the phase sequencer. It also supports per-op write-back policies: no write-back (compare/test) and write-back to port B. It sits between the instruction register / phase sequencer and the control multiplexer.

Parameters:
INSTR_W, 16, instruction width; GPF=[INSTR_W-1:INSTR_W-2], ALUF=[INSTR_W-3:INSTR_W-6], ARGF=[INSTR_W-7:INSTR_W-8], ARGA=[2*REG_AW-1:REG_AW], ARGB=[REG_AW-1:0]
REG_AW, 4, register address width (INSTR_W must equal 8+2*REG_AW)
MULTI_CYCLES, 4, ALU busy cycles for multi-cycle ops (>=1)
MULTI_MASK, 16'h1000, bit i set => ALUF==i is multi-cycle
NOWB_MASK, 16'h0800, bit i set => ALUF==i updates flags only, no register write
WRB_MASK, 16'h0000, bit i set => ALUF==i also writes port B

Ports:
CLK  in  1  clock, rising edge
RESETN  in  1  asynchronous active-low reset
INSTRUCTION  in  INSTR_W  current instruction
FETCH  in  1  phase strobe (unused, reserved)
DECODE  in  1  phase strobe
EXECUTE  in  1  phase strobe
COMMIT  in  1  phase strobe
REGA_CLKEN  out  1  register port A clock enable
REGB_CLKEN  out  1  register port B clock enable
REGA_WEN  out  1  register port A write enable
REGB_WEN  out  1  register port B write enable
REGA_ADDR  out  REG_AW  port A address
REGB_ADDR  out  REG_AW  port B address
ALUX  out  4  latched ALU operation
ALU_A_SOURCEX  out  2  ALU A source select (constants.v ALU_A_SOURCEX_*)
ALU_B_SOURCEX  out  2  ALU B source select (constants.v ALU_B_SOURCEX_*)
ALU_START  out  1  one-cycle start pulse for multi-cycle ops
STALL  out  1  hold phase sequencer in EXECUTE
FLAGS_WEN  out  1  flag register write enable

Behaviour:
- Reset (RESETN low, async): all outputs 0, except ALU_A_SOURCEX=ALU_A_SOURCEX_REG_A and ALU_B_SOURCEX=ALU_B_SOURCEX_REG_B; state IDLE; counter 0. Reset mid-operation aborts immediately, with no write.
- All outputs are registered.
- States: IDLE, READ, WAIT, WRITE.
- IDLE: on a DECODE edge with GPF==2'b11, latch ALUX, ARGF, ARGA and ARGB, then go to READ.
  - Mode ARGF decode:
    - MODE_REG_REG: A=REG_A, B=REG_B; RD_A=RD_B=1.
    - MODE_REG_U4: B=ARG_U4; RD_A=1.
    - MODE_REGB_U8: A=RB, B=ARG_U8; RD_A=1; REGA_ADDR=ARGB.
    - MODE_REGA_U8RB: A=RA, B=U8_REG_B; RD_A=RD_B=1.
  - REGA_ADDR=ARGA unless MODE_REGB_U8. REGB_ADDR=ARGB always.
  - REGA_CLKEN<=RD_A, REGB_CLKEN<=RD_B.
  - DECODE with any other GPF: ignored, outputs unchanged.
- READ, on EXECUTE:
  - Single-cycle op: go to WRITE. REGA_CLKEN/REGA_WEN<=WR_A, REGB_CLKEN/REGB_WEN<=WR_B, FLAGS_WEN<=1.
    - WR_A = !NOWB_MASK[ALUX].
    - WR_B = WRB_MASK[ALUX] & !NOWB_MASK[ALUX].
  - Multi-cycle op (MULTI_MASK[ALUX]): go to WAIT. ALU_START<=1 for one cycle, STALL<=1, cnt<=MULTI_CYCLES-1, clock enables<=0.
- WAIT: if cnt!=0, cnt<=cnt-1. Else STALL<=0, write enables and FLAGS_WEN as in the single-cycle case, go to WRITE.
  - STALL is high for exactly MULTI_CYCLES cycles.
  - Write enables appear in the cycle STALL falls.
- WRITE: on COMMIT, all CLKEN/WEN/FLAGS_WEN<=0, go to IDLE. Enables hold until COMMIT.
- Phase strobes outside their expected state (DECODE outside IDLE, EXECUTE outside READ, COMMIT outside WRITE) are ignored.
- Simultaneous strobes: only the strobe matching the current state acts.
- Counter width is clog2(MULTI_CYCLES+1).
- A mask conflict (NOWB and WRB both set) resolves to no write.

Test Plan:
- 0xC035 (ADD R3,R5, REG_REG): DECODE -> next cycle REGA_CLKEN=REGB_CLKEN=1, REGA_ADDR=3, REGB_ADDR=5; EXECUTE -> REGA_WEN=1, REGB_WEN=0, FLAGS_WEN=1, STALL=0; COMMIT -> all enables 0.
- 0xF035 (op 12, multi-cycle): EXECUTE -> ALU_START high 1 cycle, STALL high exactly 4 cycles, REGA_WEN=1 in the cycle STALL falls; a COMMIT during STALL is ignored.
- 0xEC12 (op 11, CMP): EXECUTE -> FLAGS_WEN=1, REGA_WEN=REGB_WEN=0.
- 0xC235 (REGB_U8): REGA_ADDR=5, ALU_A_SOURCEX=RB, ALU_B_SOURCEX=ARG_U8, REGB_CLKEN=0 after DECODE.
- 0x4035 (load/store group) with DECODE/EXECUTE/COMMIT -> all outputs stay at reset values.
- RESETN pulsed low during WAIT of 0xF035 -> STALL, ALU_START and enables 0 immediately, state IDLE; a following 0xC035 sequences normally.

Source files
------------

// File: rtl/alu_group_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_group_sequencer
// Purpose  : Decoder and sequencer for the ALU instruction group (GPF=2'b11).
//            Latches the ALU instruction at DECODE. Drives register-file port
//            enables and addresses, ALU operand source selects and the flag
//            write enable across DECODE/EXECUTE/COMMIT. Multi-cycle ops hold
//            STALL high so the phase sequencer stays in EXECUTE.
// Ports    : CLK, RESETN (async, active low)
//            INSTRUCTION            - current instruction word
//            FETCH                  - reserved phase strobe, not used
//            DECODE/EXECUTE/COMMIT  - phase strobes
//            REGA_/REGB_CLKEN, REGA_/REGB_WEN, REGA_/REGB_ADDR
//                                   - register file port control
//            ALUX                   - latched ALU operation
//            ALU_A/B_SOURCEX        - ALU operand source selects
//            ALU_START              - one-cycle start for multi-cycle ops
//            STALL                  - hold the phase sequencer in EXECUTE
//            FLAGS_WEN              - flag register write enable
// Revision : 1.0 - initial release
// ============================================================================
module alu_group_sequencer #(
  parameter int          INSTR_W      = 16,
  parameter int          REG_AW       = 4,   // INSTR_W must equal 8+2*REG_AW
  parameter int          MULTI_CYCLES = 4,
  parameter logic [15:0] MULTI_MASK   = 16'h1000,
  parameter logic [15:0] NOWB_MASK    = 16'h0800,
  parameter logic [15:0] WRB_MASK     = 16'h0000
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [INSTR_W-1:0] INSTRUCTION,
  input  logic               FETCH,
  input  logic               DECODE,
  input  logic               EXECUTE,
  input  logic               COMMIT,
  output logic               REGA_CLKEN,
  output logic               REGB_CLKEN,
  output logic               REGA_WEN,
  output logic               REGB_WEN,
  output logic [REG_AW-1:0]  REGA_ADDR,
  output logic [REG_AW-1:0]  REGB_ADDR,
  output logic [3:0]         ALUX,
  output logic [1:0]         ALU_A_SOURCEX,
  output logic [1:0]         ALU_B_SOURCEX,
  output logic               ALU_START,
  output logic               STALL,
  output logic               FLAGS_WEN
);

  localparam int c_CNT_W = $clog2(MULTI_CYCLES + 1);

  // Operand source encodings shared with the control multiplexer.
  localparam logic [1:0] c_ASRC_REG_A  = 2'd0;
  localparam logic [1:0] c_ASRC_RB     = 2'd1;
  localparam logic [1:0] c_ASRC_RA     = 2'd2;
  localparam logic [1:0] c_BSRC_REG_B  = 2'd0;
  localparam logic [1:0] c_BSRC_ARG_U4 = 2'd1;
  localparam logic [1:0] c_BSRC_ARG_U8 = 2'd2;
  localparam logic [1:0] c_BSRC_U8_RB  = 2'd3;

  // ARGF addressing modes.
  localparam logic [1:0] c_MODE_REG_REG   = 2'd0;
  localparam logic [1:0] c_MODE_REG_U4    = 2'd1;
  localparam logic [1:0] c_MODE_REGB_U8   = 2'd2;
  localparam logic [1:0] c_MODE_REGA_U8RB = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic              w_rega_clken_nxt, w_regb_clken_nxt;
  logic              w_rega_wen_nxt, w_regb_wen_nxt;
  logic [REG_AW-1:0] w_rega_addr_nxt, w_regb_addr_nxt;
  logic [3:0]        w_alux_nxt;
  logic [1:0]        w_asrc_nxt, w_bsrc_nxt;
  logic              w_start_nxt, w_stall_nxt, w_flags_wen_nxt;

  // Instruction fields.
  logic [1:0]        w_gpf, w_argf;
  logic [3:0]        w_aluf;
  logic [REG_AW-1:0] w_arga, w_argb;

  assign w_gpf  = INSTRUCTION[INSTR_W-1 -: 2];
  assign w_aluf = INSTRUCTION[INSTR_W-3 -: 4];
  assign w_argf = INSTRUCTION[INSTR_W-7 -: 2];
  assign w_arga = INSTRUCTION[2*REG_AW-1 -: REG_AW];
  assign w_argb = INSTRUCTION[REG_AW-1:0];

  // Write-back policy of the latched op. A NOWB/WRB conflict means no write.
  logic w_wr_a, w_wr_b, w_multi;
  assign w_wr_a  = ~NOWB_MASK[ALUX];
  assign w_wr_b  = WRB_MASK[ALUX] & ~NOWB_MASK[ALUX];
  assign w_multi = MULTI_MASK[ALUX];

  logic w_unused;
  assign w_unused = FETCH;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_rega_clken_nxt = REGA_CLKEN;
    w_regb_clken_nxt = REGB_CLKEN;
    w_rega_wen_nxt   = REGA_WEN;
    w_regb_wen_nxt   = REGB_WEN;
    w_rega_addr_nxt  = REGA_ADDR;
    w_regb_addr_nxt  = REGB_ADDR;
    w_alux_nxt       = ALUX;
    w_asrc_nxt       = ALU_A_SOURCEX;
    w_bsrc_nxt       = ALU_B_SOURCEX;
    w_start_nxt      = 1'b0;
    w_stall_nxt      = STALL;
    w_flags_wen_nxt  = FLAGS_WEN;

    case (r_state)
      S_IDLE: begin
        if (DECODE && (w_gpf == 2'b11)) begin
          w_state_nxt      = S_READ;
          w_alux_nxt       = w_aluf;
          w_rega_addr_nxt  = w_arga;
          w_regb_addr_nxt  = w_argb;
          w_rega_clken_nxt = 1'b1;
          w_regb_clken_nxt = 1'b0;
          w_rega_wen_nxt   = 1'b0;
          w_regb_wen_nxt   = 1'b0;
          w_flags_wen_nxt  = 1'b0;
          w_stall_nxt      = 1'b0;
          case (w_argf)
            c_MODE_REG_REG: begin
              w_asrc_nxt       = c_ASRC_REG_A;
              w_bsrc_nxt       = c_BSRC_REG_B;
              w_regb_clken_nxt = 1'b1;
            end
            c_MODE_REG_U4: begin
              w_asrc_nxt = c_ASRC_REG_A;
              w_bsrc_nxt = c_BSRC_ARG_U4;
            end
            c_MODE_REGB_U8: begin
              // Port A reads the ARGB register, which feeds the A operand.
              w_asrc_nxt      = c_ASRC_RB;
              w_bsrc_nxt      = c_BSRC_ARG_U8;
              w_rega_addr_nxt = w_argb;
            end
            default: begin
              w_asrc_nxt       = c_ASRC_RA;
              w_bsrc_nxt       = c_BSRC_U8_RB;
              w_regb_clken_nxt = 1'b1;
            end
          endcase
        end
      end

      S_READ: begin
        if (EXECUTE) begin
          if (w_multi) begin
            w_state_nxt      = S_WAIT;
            w_start_nxt      = 1'b1;
            w_stall_nxt      = 1'b1;
            w_cnt_nxt        = c_CNT_W'(MULTI_CYCLES - 1);
            w_rega_clken_nxt = 1'b0;
            w_regb_clken_nxt = 1'b0;
          end else begin
            w_state_nxt      = S_WRITE;
            w_rega_clken_nxt = w_wr_a;
            w_rega_wen_nxt   = w_wr_a;
            w_regb_clken_nxt = w_wr_b;
            w_regb_wen_nxt   = w_wr_b;
            w_flags_wen_nxt  = 1'b1;
          end
        end
      end

      S_WAIT: begin
        // STALL was raised with cnt=MULTI_CYCLES-1, so it stays high for
        // exactly MULTI_CYCLES cycles and the write enables rise as it falls.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end else begin
          w_state_nxt      = S_WRITE;
          w_stall_nxt      = 1'b0;
          w_rega_clken_nxt = w_wr_a;
          w_rega_wen_nxt   = w_wr_a;
          w_regb_clken_nxt = w_wr_b;
          w_regb_wen_nxt   = w_wr_b;
          w_flags_wen_nxt  = 1'b1;
        end
      end

      default: begin  // S_WRITE
        if (COMMIT) begin
          w_state_nxt      = S_IDLE;
          w_rega_clken_nxt = 1'b0;
          w_regb_clken_nxt = 1'b0;
          w_rega_wen_nxt   = 1'b0;
          w_regb_wen_nxt   = 1'b0;
          w_flags_wen_nxt  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      REGA_CLKEN    <= 1'b0;
      REGB_CLKEN    <= 1'b0;
      REGA_WEN      <= 1'b0;
      REGB_WEN      <= 1'b0;
      REGA_ADDR     <= '0;
      REGB_ADDR     <= '0;
      ALUX          <= 4'd0;
      ALU_A_SOURCEX <= c_ASRC_REG_A;
      ALU_B_SOURCEX <= c_BSRC_REG_B;
      ALU_START     <= 1'b0;
      STALL         <= 1'b0;
      FLAGS_WEN     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      REGA_CLKEN    <= w_rega_clken_nxt;
      REGB_CLKEN    <= w_regb_clken_nxt;
      REGA_WEN      <= w_rega_wen_nxt;
      REGB_WEN      <= w_regb_wen_nxt;
      REGA_ADDR     <= w_rega_addr_nxt;
      REGB_ADDR     <= w_regb_addr_nxt;
      ALUX          <= w_alux_nxt;
      ALU_A_SOURCEX <= w_asrc_nxt;
      ALU_B_SOURCEX <= w_bsrc_nxt;
      ALU_START     <= w_start_nxt;
      STALL         <= w_stall_nxt;
      FLAGS_WEN     <= w_flags_wen_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_group_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_group_sequencer
// Purpose  : Self-checking bench for alu_group_sequencer: directed scenarios
//            plus randomized transactions against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_group_sequencer;

  localparam logic [15:0] MULTI_M = 16'h1000;
  localparam logic [15:0] NOWB_M  = 16'h0800;
  localparam logic [15:0] WRB_M   = 16'h0000;
  localparam int          MC      = 4;

  localparam logic [1:0] A_REG_A = 2'd0, A_RB = 2'd1, A_RA = 2'd2;
  localparam logic [1:0] B_REG_B = 2'd0, B_U4 = 2'd1, B_U8 = 2'd2, B_U8RB = 2'd3;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [15:0] INSTRUCTION = 16'h0;
  logic        FETCH = 1'b0, DECODE = 1'b0, EXECUTE = 1'b0, COMMIT = 1'b0;
  logic        REGA_CLKEN, REGB_CLKEN, REGA_WEN, REGB_WEN;
  logic [3:0]  REGA_ADDR, REGB_ADDR, ALUX;
  logic [1:0]  ALU_A_SOURCEX, ALU_B_SOURCEX;
  logic        ALU_START, STALL, FLAGS_WEN;

  int n_checks = 0;
  int n_pass   = 0;

  alu_group_sequencer dut (
    .CLK(CLK), .RESETN(RESETN), .INSTRUCTION(INSTRUCTION), .FETCH(FETCH),
    .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT),
    .REGA_CLKEN(REGA_CLKEN), .REGB_CLKEN(REGB_CLKEN),
    .REGA_WEN(REGA_WEN), .REGB_WEN(REGB_WEN),
    .REGA_ADDR(REGA_ADDR), .REGB_ADDR(REGB_ADDR), .ALUX(ALUX),
    .ALU_A_SOURCEX(ALU_A_SOURCEX), .ALU_B_SOURCEX(ALU_B_SOURCEX),
    .ALU_START(ALU_START), .STALL(STALL), .FLAGS_WEN(FLAGS_WEN)
  );

  always #5 CLK = ~CLK;

  // Output vector layout:
  // {cka,ckb,wa,wb,aaddr,baddr,alux,asrc,bsrc,start,stall,flags}
  function automatic logic [22:0] obs();
    return {REGA_CLKEN, REGB_CLKEN, REGA_WEN, REGB_WEN, REGA_ADDR, REGB_ADDR,
            ALUX, ALU_A_SOURCEX, ALU_B_SOURCEX, ALU_START, STALL, FLAGS_WEN};
  endfunction

  function automatic logic [22:0] pack(input logic cka, ckb, wa, wb,
                                       input logic [3:0] aa, ba, alu,
                                       input logic [1:0] asrc, bsrc,
                                       input logic st, sl, fw);
    return {cka, ckb, wa, wb, aa, ba, alu, asrc, bsrc, st, sl, fw};
  endfunction

  // One clock cycle of strobes, applied and released on falling edges.
  task automatic step(input logic d, input logic e, input logic c);
    DECODE = d; EXECUTE = e; COMMIT = c;
    @(negedge CLK);
    DECODE = 1'b0; EXECUTE = 1'b0; COMMIT = 1'b0;
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    logic [22:0] e;
    e = '0;
    n_checks++;
    if (obs() !== e) $display("FAIL reset_hold: got %h exp %h", obs(), e);
    else n_pass++;
    RESETN = 1'b1;
    step(0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL reset_release: got %h exp %h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_ldst();
    logic [22:0] e;
    e = '0;
    INSTRUCTION = 16'h4035;
    step(1, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL ldst_decode: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 1, 0);
    step(0, 0, 1);
    step(1, 1, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL ldst_strobes: got %h exp %h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [22:0] e;
    INSTRUCTION = 16'hC035;
    step(1, 0, 0);
    e = pack(1, 1, 0, 0, 4'd3, 4'd5, 4'd0, A_REG_A, B_REG_B, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL add_decode: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 1, 0);
    e = pack(1, 0, 1, 0, 4'd3, 4'd5, 4'd0, A_REG_A, B_REG_B, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL add_execute: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL add_hold: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 0, 1);
    e = pack(0, 0, 0, 0, 4'd3, 4'd5, 4'd0, A_REG_A, B_REG_B, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL add_commit: got %h exp %h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_multi();
    logic [22:0] e;
    INSTRUCTION = 16'hF035;
    step(1, 0, 0);
    e = pack(1, 1, 0, 0, 4'd3, 4'd5, 4'd12, A_REG_A, B_REG_B, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL mul_decode: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 1, 0);
    e = pack(0, 0, 0, 0, 4'd3, 4'd5, 4'd12, A_REG_A, B_REG_B, 1, 1, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL mul_start: got %h exp %h", obs(), e);
    else n_pass++;
    for (int k = 1; k < MC; k++) begin
      step(0, 0, 1);  // COMMIT while stalled must be ignored
      e = pack(0, 0, 0, 0, 4'd3, 4'd5, 4'd12, A_REG_A, B_REG_B, 0, 1, 0);
      n_checks++;
      if (obs() !== e) $display("FAIL mul_stall%0d: got %h exp %h", k, obs(), e);
      else n_pass++;
    end
    step(0, 0, 0);
    e = pack(1, 0, 1, 0, 4'd3, 4'd5, 4'd12, A_REG_A, B_REG_B, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL mul_release: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 0, 1);
    e = pack(0, 0, 0, 0, 4'd3, 4'd5, 4'd12, A_REG_A, B_REG_B, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL mul_commit: got %h exp %h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_cmp();
    logic [22:0] e;
    INSTRUCTION = 16'hEC12;
    step(1, 0, 0);
    step(0, 1, 0);
    e = pack(0, 0, 0, 0, 4'd1, 4'd2, 4'd11, A_REG_A, B_REG_B, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL cmp_execute: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 0, 1);
  endtask

  task automatic test_regb_u8();
    logic [22:0] e;
    INSTRUCTION = 16'hC235;
    step(1, 0, 0);
    e = pack(1, 0, 0, 0, 4'd5, 4'd5, 4'd0, A_RB, B_U8, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL regbu8_decode: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 1, 0);
    step(0, 0, 1);
  endtask

  task automatic test_reset_in_wait();
    logic [22:0] e;
    INSTRUCTION = 16'hF035;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    RESETN = 1'b0;
    #2;
    e = '0;
    n_checks++;
    if (obs() !== e) $display("FAIL rst_wait_async: got %h exp %h", obs(), e);
    else n_pass++;
    @(negedge CLK);
    RESETN = 1'b1;
    INSTRUCTION = 16'hC035;
    step(1, 0, 0);
    e = pack(1, 1, 0, 0, 4'd3, 4'd5, 4'd0, A_REG_A, B_REG_B, 0, 0, 0);
    n_checks++;
    if (obs() !== e) $display("FAIL rst_wait_redecode: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 1, 0);
    e = pack(1, 0, 1, 0, 4'd3, 4'd5, 4'd0, A_REG_A, B_REG_B, 0, 0, 1);
    n_checks++;
    if (obs() !== e) $display("FAIL rst_wait_execute: got %h exp %h", obs(), e);
    else n_pass++;
    step(0, 0, 1);
  endtask

  // Random transactions with stray and simultaneous strobes; expectations
  // come from the instruction fields and the mask parameters directly.
  task automatic test_random();
    logic [22:0] last, e;
    logic [15:0] ins;
    logic [3:0]  alu, aa, ba;
    logic [1:0]  mode, asrc, bsrc;
    logic        rda, rdb, wa, wb;
    RESETN = 1'b0;
    #2;
    @(negedge CLK);
    RESETN = 1'b1;
    last = '0;
    for (int t = 0; t < 40; t++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:14] = 2'b11;
      case ($urandom_range(0, 3))
        0: ins[13:10] = 4'd12;
        1: ins[13:10] = 4'd11;
        default: ;
      endcase
      INSTRUCTION = ins;
      if (ins[15:14] != 2'b11) begin
        step(1, rbit(), rbit());
        step(0, 1, 1);
        n_checks++;
        if (obs() !== last) $display("FAIL rnd_ignore t%0d: got %h exp %h", t, obs(), last);
        else n_pass++;
        continue;
      end
      alu = ins[13:10]; mode = ins[9:8]; ba = ins[3:0];
      aa = (mode == 2'd2) ? ins[3:0] : ins[7:4];
      case (mode)
        2'd0:    begin asrc = A_REG_A; bsrc = B_REG_B; rda = 1; rdb = 1; end
        2'd1:    begin asrc = A_REG_A; bsrc = B_U4;    rda = 1; rdb = 0; end
        2'd2:    begin asrc = A_RB;    bsrc = B_U8;    rda = 1; rdb = 0; end
        default: begin asrc = A_RA;    bsrc = B_U8RB;  rda = 1; rdb = 1; end
      endcase
      wa = !NOWB_M[alu];
      wb = WRB_M[alu] && !NOWB_M[alu];
      step(1, rbit(), rbit());
      e = pack(rda, rdb, 0, 0, aa, ba, alu, asrc, bsrc, 0, 0, 0);
      n_checks++;
      if (obs() !== e) $display("FAIL rnd_decode t%0d: got %h exp %h", t, obs(), e);
      else n_pass++;
      step(1, 0, 1);
      n_checks++;
      if (obs() !== e) $display("FAIL rnd_read_hold t%0d: got %h exp %h", t, obs(), e);
      else n_pass++;
      step(rbit(), 1, rbit());
      if (MULTI_M[alu]) begin
        e = pack(0, 0, 0, 0, aa, ba, alu, asrc, bsrc, 1, 1, 0);
        n_checks++;
        if (obs() !== e) $display("FAIL rnd_start t%0d: got %h exp %h", t, obs(), e);
        else n_pass++;
        for (int k = 1; k < MC; k++) begin
          step(rbit(), rbit(), rbit());
          e = pack(0, 0, 0, 0, aa, ba, alu, asrc, bsrc, 0, 1, 0);
          n_checks++;
          if (obs() !== e) $display("FAIL rnd_stall t%0d: got %h exp %h", t, obs(), e);
          else n_pass++;
        end
        step(rbit(), rbit(), rbit());
      end
      e = pack(wa, wb, wa, wb, aa, ba, alu, asrc, bsrc, 0, 0, 1);
      n_checks++;
      if (obs() !== e) $display("FAIL rnd_write t%0d: got %h exp %h", t, obs(), e);
      else n_pass++;
      step(1, 1, 0);
      n_checks++;
      if (obs() !== e) $display("FAIL rnd_write_hold t%0d: got %h exp %h", t, obs(), e);
      else n_pass++;
      step(0, 0, 1);
      e = pack(0, 0, 0, 0, aa, ba, alu, asrc, bsrc, 0, 0, 0);
      n_checks++;
      if (obs() !== e) $display("FAIL rnd_commit t%0d: got %h exp %h", t, obs(), e);
      else n_pass++;
      last = e;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    test_reset();
    test_ldst();
    test_add();
    test_multi();
    test_cmp();
    test_regb_u8();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
